// File: rtl/mem_access_pkg.sv
// Shared definitions for the mem_access load/store unit.
// Holds funct3 encodings, access sizes, FSM states and the default ack timeout.
package mem_access_pkg;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is carried by funct3[1:0]; bit 2 only selects zero extension.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Illegal funct3 codes are reported as misaligned so they never reach the bus.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: is_misaligned = 1'b0;
            F3_H, F3_HU: is_misaligned = addr_lo[0];
            F3_W:        is_misaligned = (addr_lo != 2'b00);
            default:     is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response and data-bus signals of the mem_access unit.
// slave = the mem_access block itself; master = execute stage plus bus/memory model.
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              mem_we_i;
    logic [2:0]        funct3_i;
    logic [ADDR_W-1:0] alu_C_i;
    logic [31:0]       rf_rd2_i;

    logic              dbus_req_o;
    logic              dbus_we_o;
    logic [ADDR_W-1:0] dbus_addr_o;
    logic [31:0]       dbus_wdata_o;
    logic [3:0]        dbus_be_o;
    logic              dbus_ack_i;
    logic [31:0]       dbus_rdata_i;

    logic              rsp_valid_o;
    logic [31:0]       rd_data_o;
    logic              misalign_o;
    logic              bus_err_o;

    modport slave (
        input  req_valid_i, mem_we_i, funct3_i, alu_C_i, rf_rd2_i,
        input  dbus_ack_i, dbus_rdata_i,
        output req_ready_o,
        output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o,
        output rsp_valid_o, rd_data_o, misalign_o, bus_err_o
    );

    modport master (
        output req_valid_i, mem_we_i, funct3_i, alu_C_i, rf_rd2_i,
        output dbus_ack_i, dbus_rdata_i,
        input  req_ready_o,
        input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o,
        input  rsp_valid_o, rd_data_o, misalign_o, bus_err_o
    );

endinterface

// File: rtl/mem_access_load_extend.sv
// Load lane selection and sign/zero extension of a 32-bit bus read word.
// Purely combinational; lane is the byte offset of the original access.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // Word accesses are aligned, so lane is 0 and the shift is a no-op for them.
    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        data = shifted;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data = {24'h000000, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Load/store unit: accepts one memory op, runs one data-bus cycle, returns one response.
// Define MEM_ACCESS_TIMEOUT_EN to abort bus cycles that see no ack within ACK_TIMEOUT cycles.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
    parameter int ADDR_W      = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mem_access_if.slave mif
);

    state_t            state_reg;
    logic              req_ready_reg;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        be_reg;
    logic              dbus_req_reg;
    logic              rsp_valid_reg;
    logic [31:0]       rd_data_reg;
    logic              misalign_reg;
    logic              bus_err_reg;

    logic [1:0]        size_next;
    logic [1:0]        lane_next;
    logic              misalign_next;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;
    logic [31:0]       load_data;
    logic              expired;

    assign size_next     = mif.funct3_i[1:0];
    assign lane_next     = mif.alu_C_i[1:0];
    assign misalign_next = is_misaligned(mif.funct3_i, lane_next);

    // Per-lane byte enable and store data replication for the incoming op.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);

        assign be_next[gi] = (size_next == SIZE_W)
                          || ((size_next == SIZE_H) && (LANE[1] == lane_next[1]))
                          || ((size_next == SIZE_B) && (LANE == lane_next));

        assign wdata_next[8*gi +: 8] = (size_next == SIZE_W) ? mif.rf_rd2_i[8*gi +: 8] :
                                       (size_next == SIZE_H) ? mif.rf_rd2_i[8*(gi%2) +: 8] :
                                                               mif.rf_rd2_i[7:0];
    end

    load_extend u_load_extend (
        .rdata  (mif.dbus_rdata_i),
        .lane   (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .data   (load_data)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg;

    // Expiry marks the last BUS cycle; an ack in that same cycle still completes normally.
    assign expired = (cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (state_reg == BUS) begin
            cnt_reg <= cnt_reg + 1'b1;
        end else begin
            cnt_reg <= '0;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b0;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= '0;
            wdata_reg     <= 32'h0;
            be_reg        <= 4'h0;
            dbus_req_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rd_data_reg   <= 32'h0;
            misalign_reg  <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (mif.req_valid_i && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        we_reg        <= mif.mem_we_i;
                        funct3_reg    <= mif.funct3_i;
                        addr_reg      <= mif.alu_C_i;
                        wdata_reg     <= wdata_next;
                        be_reg        <= be_next;
                        if (misalign_next) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rd_data_reg   <= 32'h0;
                            misalign_reg  <= 1'b1;
                            bus_err_reg   <= 1'b0;
                        end else begin
                            state_reg    <= BUS;
                            dbus_req_reg <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (mif.dbus_ack_i) begin
                        state_reg     <= RESP;
                        dbus_req_reg  <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rd_data_reg   <= we_reg ? 32'h0 : load_data;
                        misalign_reg  <= 1'b0;
                        bus_err_reg   <= 1'b0;
                    end else if (expired) begin
                        state_reg     <= RESP;
                        dbus_req_reg  <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rd_data_reg   <= 32'h0;
                        misalign_reg  <= 1'b0;
                        bus_err_reg   <= 1'b1;
                    end
                end
                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b0;
                    dbus_req_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mif.req_ready_o  = req_ready_reg;
    assign mif.dbus_req_o   = dbus_req_reg;
    assign mif.dbus_we_o    = dbus_req_reg & we_reg;
    assign mif.dbus_addr_o  = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mif.dbus_wdata_o = wdata_reg;
    assign mif.dbus_be_o    = be_reg;
    assign mif.rsp_valid_o  = rsp_valid_reg;
    assign mif.rd_data_o    = rd_data_reg;
    assign mif.misalign_o   = misalign_reg;
    assign mif.bus_err_o    = bus_err_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected responses are queued per op and popped on rsp_valid_o.
// Timeout cases run when MEM_ACCESS_TIMEOUT_EN is defined (ACK_TIMEOUT = 4).
module tb_mem_access;
    import mem_access_pkg::*;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        err;
    } rsp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    rsp_t sb[$];

    mem_access_if #(.ADDR_W(32)) mif ();

    mem_access #(
        .ACK_TIMEOUT (4),
        .ADDR_W      (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=stuck expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] rd, input logic mis, input logic err);
        rsp_t e;
        e.rd  = rd;
        e.mis = mis;
        e.err = err;
        sb.push_back(e);
    endtask

    // Issue one op from an idle negedge; ack on the ack_at-th BUS cycle (0 = never).
    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rd2, input logic [31:0] rdata,
                          input int ack_at, input int exp_bus, input logic [31:0] exp_baddr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int   cyc;
        int   bus_cycles;
        bit   got;
        rsp_t e;
        cyc        = 0;
        bus_cycles = 0;
        got        = 1'b0;
        e.rd       = 32'h0;
        e.mis      = 1'b0;
        e.err      = 1'b0;
        check({tag, "/ready"}, 32'(mif.req_ready_o), 32'd1);
        mif.req_valid_i  = 1'b1;
        mif.mem_we_i     = we;
        mif.funct3_i     = f3;
        mif.alu_C_i      = addr;
        mif.rf_rd2_i     = rd2;
        mif.dbus_rdata_i = rdata;
        @(negedge clk);
        mif.req_valid_i = 1'b0;
        while (!got && cyc < 40) begin
            cyc++;
            if (mif.dbus_req_o) begin
                bus_cycles++;
                if (bus_cycles == 1) begin
                    check({tag, "/addr"}, mif.dbus_addr_o, exp_baddr);
                    check({tag, "/be"}, 32'(mif.dbus_be_o), 32'(exp_be));
                    check({tag, "/wdata"}, mif.dbus_wdata_o, exp_wdata);
                    check({tag, "/we"}, 32'(mif.dbus_we_o), 32'(we));
                end
                if (bus_cycles == ack_at) mif.dbus_ack_i = 1'b1;
            end
            if (mif.rsp_valid_o) begin
                got = 1'b1;
                check({tag, "/latency"}, 32'(cyc), 32'(exp_bus + 1));
                check({tag, "/bus_cycles"}, 32'(bus_cycles), 32'(exp_bus));
                if (sb.size() == 0) begin
                    check({tag, "/sb_nonempty"}, 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check({tag, "/rd_data"}, mif.rd_data_o, e.rd);
                    check({tag, "/misalign"}, 32'(mif.misalign_o), 32'(e.mis));
                    check({tag, "/bus_err"}, 32'(mif.bus_err_o), 32'(e.err));
                end
            end else begin
                @(negedge clk);
                mif.dbus_ack_i = 1'b0;
            end
        end
        check({tag, "/rsp_seen"}, 32'(got), 32'd1);
        @(negedge clk);
        check({tag, "/rsp_one_cycle"}, 32'(mif.rsp_valid_o), 32'd0);
        check({tag, "/req_dropped"}, 32'(mif.dbus_req_o), 32'd0);
        check({tag, "/ready_again"}, 32'(mif.req_ready_o), 32'd1);
        if (got) check({tag, "/rd_held"}, mif.rd_data_o, e.rd);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        mif.req_valid_i  = 1'b0;
        mif.mem_we_i     = 1'b0;
        mif.funct3_i     = 3'b000;
        mif.alu_C_i      = 32'h0;
        mif.rf_rd2_i     = 32'h0;
        mif.dbus_ack_i   = 1'b0;
        mif.dbus_rdata_i = 32'h0;

        repeat (2) @(negedge clk);
        check("rst/dbus_req", 32'(mif.dbus_req_o), 32'd0);
        check("rst/rsp_valid", 32'(mif.rsp_valid_o), 32'd0);
        check("rst/ready", 32'(mif.req_ready_o), 32'd0);
        check("rst/rd_data", mif.rd_data_o, 32'h0);
        check("rst/misalign", 32'(mif.misalign_o), 32'd0);
        check("rst/bus_err", 32'(mif.bus_err_o), 32'd0);
        rst = 1'b0;
        check("rst/ready_at_release", 32'(mif.req_ready_o), 32'd0);
        @(negedge clk);
        check("rst/ready_after_release", 32'(mif.req_ready_o), 32'd1);

        expect_rsp(32'hDEADBEEF, 1'b0, 1'b0);
        run_op("lw_100", 1'b0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 2, 2, 32'h100, 4'b1111, 32'h0);

        // A stray ack while idle must not produce a response.
        mif.dbus_ack_i = 1'b1;
        @(negedge clk);
        mif.dbus_ack_i = 1'b0;
        check("idle_ack/rsp_valid", 32'(mif.rsp_valid_o), 32'd0);
        check("idle_ack/dbus_req", 32'(mif.dbus_req_o), 32'd0);

        expect_rsp(32'hFFFFFF80, 1'b0, 1'b0);
        run_op("lb_103", 1'b0, F3_B, 32'h103, 32'h0, 32'h80112233, 1, 1, 32'h100, 4'b1000, 32'h0);
        expect_rsp(32'h00000080, 1'b0, 1'b0);
        run_op("lbu_103", 1'b0, F3_BU, 32'h103, 32'h0, 32'h80112233, 1, 1, 32'h100, 4'b1000, 32'h0);
        expect_rsp(32'h0, 1'b0, 1'b0);
        run_op("sh_202", 1'b1, F3_H, 32'h202, 32'h0000ABCD, 32'h55555555, 1, 1, 32'h200, 4'b1100, 32'hABCDABCD);
        expect_rsp(32'h0, 1'b1, 1'b0);
        run_op("lw_101", 1'b0, F3_W, 32'h101, 32'h0, 32'h12345678, 0, 0, 32'h0, 4'b0000, 32'h0);
        expect_rsp(32'hFFFF8001, 1'b0, 1'b0);
        run_op("lh_102", 1'b0, F3_H, 32'h102, 32'h0, 32'h80017FFF, 3, 3, 32'h100, 4'b1100, 32'h0);
        expect_rsp(32'h00008001, 1'b0, 1'b0);
        run_op("lhu_002", 1'b0, F3_HU, 32'h002, 32'h0, 32'h80017FFF, 1, 1, 32'h000, 4'b1100, 32'h0);
        expect_rsp(32'h00007FFF, 1'b0, 1'b0);
        run_op("lh_100", 1'b0, F3_H, 32'h100, 32'h0, 32'h80017FFF, 1, 1, 32'h100, 4'b0011, 32'h0);
        expect_rsp(32'h0, 1'b0, 1'b0);
        run_op("sb_001", 1'b1, F3_B, 32'h001, 32'h12345678, 32'h0, 2, 2, 32'h000, 4'b0010, 32'h78787878);
        expect_rsp(32'h0, 1'b0, 1'b0);
        run_op("sw_00c", 1'b1, F3_W, 32'h00C, 32'hCAFEF00D, 32'h0, 1, 1, 32'h00C, 4'b1111, 32'hCAFEF00D);
        expect_rsp(32'h0, 1'b1, 1'b0);
        run_op("sh_201", 1'b1, F3_H, 32'h201, 32'h0000ABCD, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
        expect_rsp(32'h0, 1'b1, 1'b0);
        run_op("f3_011", 1'b0, 3'b011, 32'h000, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
        expect_rsp(32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("lb_002", 1'b0, F3_B, 32'h002, 32'h0, 32'h12FF3456, 1, 1, 32'h000, 4'b0100, 32'h0);

        // Reset pulse in the middle of a bus cycle aborts the op silently.
        mif.req_valid_i = 1'b1;
        mif.mem_we_i    = 1'b0;
        mif.funct3_i    = F3_W;
        mif.alu_C_i     = 32'h300;
        @(negedge clk);
        mif.req_valid_i = 1'b0;
        check("abort/dbus_req_up", 32'(mif.dbus_req_o), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("abort/dbus_req_async", 32'(mif.dbus_req_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort/no_rsp0", 32'(mif.rsp_valid_o), 32'd0);
        @(negedge clk);
        check("abort/no_rsp1", 32'(mif.rsp_valid_o), 32'd0);
        check("abort/ready", 32'(mif.req_ready_o), 32'd1);
        check("abort/dbus_req_low", 32'(mif.dbus_req_o), 32'd0);

        expect_rsp(32'h01234567, 1'b0, 1'b0);
        run_op("lw_104", 1'b0, F3_W, 32'h104, 32'h0, 32'h01234567, 1, 1, 32'h104, 4'b1111, 32'h0);

`ifdef MEM_ACCESS_TIMEOUT_EN
        expect_rsp(32'h0, 1'b0, 1'b1);
        run_op("lw_timeout", 1'b0, F3_W, 32'h108, 32'h0, 32'h11111111, 0, 4, 32'h108, 4'b1111, 32'h0);
        expect_rsp(32'hA5A50F0F, 1'b0, 1'b0);
        run_op("lw_ack_at_expiry", 1'b0, F3_W, 32'h10C, 32'h0, 32'hA5A50F0F, 4, 4, 32'h10C, 4'b1111, 32'h0);
`else
        expect_rsp(32'hA5A50F0F, 1'b0, 1'b0);
        run_op("lw_long_wait", 1'b0, F3_W, 32'h108, 32'h0, 32'hA5A50F0F, 12, 12, 32'h108, 4'b1111, 32'h0);
`endif

        check("sb/drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
